// File: rtl/conv_layer_input_loader.sv
// Feeder for the convolution layer's input row cache. Reads image rows from a
// synchronous single-port ROM and streams pixels tagged with read_index and
// preload_cycle. A preload streams the first KERNEL_SIZE rows with a
// bank-shift marker between them; a load streams the next single row.
module conv_layer_input_loader #(
  parameter int WIDTH       = 32,
  parameter int IMAGE_SIZE  = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int ADDR_WIDTH  = 6,
  parameter int ROM_DEPTH   = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            cmd,
  input  logic [WIDTH-1:0]      rom_data,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [WIDTH-1:0]      pixel_out,
  output logic [4:0]            read_index,
  output logic [1:0]            preload_cycle,
  output logic [1:0]            ack,
  output logic                  image_done
);

  localparam int CNT_W = $clog2(IMAGE_SIZE + 1);

  localparam logic [1:0] CMD_PRELOAD = 2'd1;
  localparam logic [1:0] CMD_LOAD    = 2'd3;
  localparam logic [1:0] ACK_IDLE    = 2'd0;
  localparam logic [1:0] ACK_PRELOAD = 2'd1;
  localparam logic [1:0] ACK_LOAD    = 2'd3;
  localparam logic [4:0] IDX_IDLE    = 5'd31;
  localparam logic [4:0] IDX_SHIFT   = 5'd8;

  localparam logic [CNT_W-1:0] LAST_COL  = CNT_W'(IMAGE_SIZE - 1);
  localparam logic [CNT_W-1:0] MARK_COL  = CNT_W'(IMAGE_SIZE);
  localparam logic [CNT_W-1:0] ROW_END   = CNT_W'(IMAGE_SIZE);
  localparam logic [1:0]       LAST_PROW = 2'(KERNEL_SIZE - 1);

  // The whole image must fit in the ROM.
  if (ROM_DEPTH < IMAGE_SIZE * IMAGE_SIZE) begin : g_bad_depth
    $error("ROM_DEPTH too small for IMAGE_SIZE");
  end

  typedef enum logic [1:0] {S_IDLE, S_PRELOAD, S_LOAD, S_ACK} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [4:0]            read_index_q, read_index_d;
  logic [1:0]            preload_cycle_q, preload_cycle_d;
  logic [1:0]            ack_q, ack_d;
  logic [CNT_W-1:0]      row_ptr_q, row_ptr_d;
  // col is the column currently on rom_addr; MARK_COL means shift-marker cycle.
  logic [CNT_W-1:0]      col_q, col_d;
  logic [1:0]            prow_q, prow_d;
  logic [1:0]            ack_code_q, ack_code_d;
  logic                  inc_row_q, inc_row_d;

  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [CNT_W-1:0] row,
                                                    input logic [CNT_W-1:0] c);
    logic [31:0] full;
    full = 32'(row) * IMAGE_SIZE + 32'(c);
    return full[ADDR_WIDTH-1:0];
  endfunction

  // Next-state logic: tags are registered one cycle behind the address
  // that fetched the matching ROM word.
  always_comb begin
    // NOTE: every _d gets a default first so no path infers a latch.
    state_d         = state_q;
    rom_addr_d      = rom_addr_q;
    read_index_d    = IDX_IDLE;
    preload_cycle_d = preload_cycle_q;
    ack_d           = ACK_IDLE;
    row_ptr_d       = row_ptr_q;
    col_d           = col_q;
    prow_d          = prow_q;
    ack_code_d      = ack_code_q;
    inc_row_d       = inc_row_q;

    case (state_q)
      S_IDLE: begin
        if (cmd == CMD_PRELOAD) begin
          state_d    = S_PRELOAD;
          row_ptr_d  = '0;
          prow_d     = '0;
          col_d      = '0;
          rom_addr_d = addr_of('0, '0);
        end else if (cmd == CMD_LOAD) begin
          if (row_ptr_q < ROW_END) begin
            state_d    = S_LOAD;
            col_d      = '0;
            rom_addr_d = addr_of(row_ptr_q, '0);
          end else begin
            // Image exhausted: acknowledge without streaming.
            state_d    = S_ACK;
            ack_code_d = ACK_LOAD;
            inc_row_d  = 1'b0;
          end
        end
      end

      S_PRELOAD: begin
        preload_cycle_d = prow_q;
        if (col_q == MARK_COL) begin
          // Shift marker: fetching pauses, next row's address already on rom_addr.
          read_index_d = IDX_SHIFT;
          prow_d       = prow_q + 2'd1;
          col_d        = '0;
        end else begin
          read_index_d = 5'(col_q);
          if (col_q == LAST_COL) begin
            row_ptr_d = row_ptr_q + CNT_W'(1);
            if (prow_q == LAST_PROW) begin
              state_d    = S_ACK;
              ack_code_d = ACK_PRELOAD;
              inc_row_d  = 1'b0;
              col_d      = '0;
            end else begin
              col_d      = MARK_COL;
              rom_addr_d = addr_of(row_ptr_q + CNT_W'(1), '0);
            end
          end else begin
            col_d      = col_q + CNT_W'(1);
            rom_addr_d = addr_of(row_ptr_q, col_q + CNT_W'(1));
          end
        end
      end

      S_LOAD: begin
        read_index_d = 5'(col_q);
        if (col_q == LAST_COL) begin
          state_d    = S_ACK;
          ack_code_d = ACK_LOAD;
          inc_row_d  = 1'b1;
          col_d      = '0;
        end else begin
          col_d      = col_q + CNT_W'(1);
          rom_addr_d = addr_of(row_ptr_q, col_q + CNT_W'(1));
        end
      end

      S_ACK: begin
        ack_d   = ack_code_q;
        state_d = S_IDLE;
        if (inc_row_q) row_ptr_d = row_ptr_q + CNT_W'(1);
        if (ack_code_q == ACK_PRELOAD) preload_cycle_d = 2'd3;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      rom_addr_q      <= '0;
      read_index_q    <= IDX_IDLE;
      preload_cycle_q <= '0;
      ack_q           <= ACK_IDLE;
      row_ptr_q       <= '0;
      col_q           <= '0;
      prow_q          <= '0;
      ack_code_q      <= ACK_IDLE;
      inc_row_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q         <= state_d;
      rom_addr_q      <= rom_addr_d;
      read_index_q    <= read_index_d;
      preload_cycle_q <= preload_cycle_d;
      ack_q           <= ack_d;
      row_ptr_q       <= row_ptr_d;
      col_q           <= col_d;
      prow_q          <= prow_d;
      ack_code_q      <= ack_code_d;
      inc_row_q       <= inc_row_d;
    end
  end

  assign rom_addr      = rom_addr_q;
  assign read_index    = read_index_q;
  assign preload_cycle = preload_cycle_q;
  assign ack           = ack_q;
  assign pixel_out     = rom_data;
  assign image_done    = (row_ptr_q == ROW_END);

endmodule

// File: tb/tb_conv_layer_input_loader.sv
// Directed bench for conv_layer_input_loader: a per-cycle vector table covers
// preload, loads, ignored commands and end of image; hand sequences cover
// reset state and reset in the middle of a load.
module tb_conv_layer_input_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cmd;
  logic [31:0] rom_data;
  logic [5:0]  rom_addr;
  logic [31:0] pixel_out;
  logic [4:0]  read_index;
  logic [1:0]  preload_cycle;
  logic [1:0]  ack;
  logic        image_done;

  int n_checks = 0;
  int n_errors = 0;

  conv_layer_input_loader #(
    .WIDTH(32), .IMAGE_SIZE(8), .KERNEL_SIZE(3), .ADDR_WIDTH(6), .ROM_DEPTH(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .rom_data(rom_data),
    .rom_addr(rom_addr), .pixel_out(pixel_out), .read_index(read_index),
    .preload_cycle(preload_cycle), .ack(ack), .image_done(image_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_val(input int a);
    return 32'h0000_1000 + 32'(a);
  endfunction

  // Synchronous ROM model, one cycle of latency.
  always @(posedge clk) rom_data <= rom_val(int'(rom_addr));

  typedef struct {
    logic [1:0]  cmd;
    logic [4:0]  ri;
    logic [1:0]  pc;
    logic [31:0] px;
    bit          px_care;
    logic [1:0]  ack;
    bit          done;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] c, input logic [4:0] ri, input logic [1:0] pc,
                     input logic [31:0] px, input bit care, input logic [1:0] ak,
                     input bit dn);
    vec_t v;
    v.cmd = c; v.ri = ri; v.pc = pc; v.px = px; v.px_care = care; v.ack = ak; v.done = dn;
    vecs.push_back(v);
  endtask

  // Full preload from the command edge through the ack cycle.
  task automatic add_preload(input logic [1:0] hold, input logic [1:0] pc0);
    add(2'd1, 5'd31, pc0, 0, 0, 2'd0, 0);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 8; c++)
        add(hold, 5'(c), 2'(r), rom_val(r * 8 + c), 1, 2'd0, 0);
      if (r < 2) add(hold, 5'd8, 2'(r), 0, 0, 2'd0, 0);
    end
    add(hold, 5'd31, 2'd3, 0, 0, 2'd1, 0);
  endtask

  task automatic step(input logic [1:0] c);
    cmd = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;

    // Preload with LOAD_START held throughout; the held load starts at E28.
    add_preload(2'd3, 2'd0);
    for (int row = 3; row < 8; row++) begin
      add(2'd3, 5'd31, 2'd3, 0, 0, 2'd0, 0);
      for (int c = 0; c < 8; c++)
        add(2'd0, 5'(c), 2'd3, rom_val(row * 8 + c), 1, 2'd0, 0);
      add(2'd0, 5'd31, 2'd3, 0, 0, 2'd3, row == 7);
      // SHIFT_START pulsed in IDLE must do nothing.
      add(2'd2, 5'd31, 2'd3, 0, 0, 2'd0, row == 7);
    end
    // Load at end of image: immediate ack, no tags.
    add(2'd3, 5'd31, 2'd3, 0, 0, 2'd0, 1);
    add(2'd0, 5'd31, 2'd3, 0, 0, 2'd3, 1);
    add(2'd0, 5'd31, 2'd3, 0, 0, 2'd0, 1);
    // A fresh preload clears image_done and restarts at mem[0].
    add_preload(2'd0, 2'd3);
    add(2'd0, 5'd31, 2'd3, 0, 0, 2'd0, 0);

    // Reset state.
    rst_n = 1'b0;
    cmd   = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset read_index", 32'(read_index), 32'd31);
    check("reset preload_cycle", 32'(preload_cycle), 32'd0);
    check("reset ack", 32'(ack), 32'd0);
    check("reset rom_addr", 32'(rom_addr), 32'd0);
    check("reset image_done", 32'(image_done), 32'd0);
    rst_n = 1'b1;
    step(2'd0);

    // Table-driven run.
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].cmd);
      check($sformatf("vec%0d read_index", i), 32'(read_index), 32'(vecs[i].ri));
      check($sformatf("vec%0d preload_cycle", i), 32'(preload_cycle), 32'(vecs[i].pc));
      check($sformatf("vec%0d ack", i), 32'(ack), 32'(vecs[i].ack));
      check($sformatf("vec%0d image_done", i), 32'(image_done), 32'(vecs[i].done));
      if (vecs[i].px_care)
        check($sformatf("vec%0d pixel_out", i), pixel_out, vecs[i].px);
    end

    // Row 3 load, reset asserted at tag index 4.
    step(2'd3);
    check("load row3 rom_addr", 32'(rom_addr), 32'd24);
    found = 0;
    for (int k = 0; k < 20; k++) begin
      step(2'd0);
      if (read_index == 5'd4) begin
        found = 1;
        break;
      end
    end
    check("reach tag 4", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midreset read_index", 32'(read_index), 32'd31);
    check("midreset ack", 32'(ack), 32'd0);
    check("midreset preload_cycle", 32'(preload_cycle), 32'd0);
    check("midreset rom_addr", 32'(rom_addr), 32'd0);
    check("midreset image_done", 32'(image_done), 32'd0);
    check("midreset pixel passthrough", pixel_out, rom_data);
    step(2'd0);
    check("held reset ack", 32'(ack), 32'd0);
    rst_n = 1'b1;
    step(2'd0);

    // Preload after reset starts from row 0.
    step(2'd1);
    check("post-reset preload rom_addr", 32'(rom_addr), 32'd0);
    check("post-reset preload ri E0", 32'(read_index), 32'd31);
    step(2'd0);
    check("post-reset ri E1", 32'(read_index), 32'd0);
    check("post-reset pc E1", 32'(preload_cycle), 32'd0);
    check("post-reset px E1", pixel_out, rom_val(0));
    step(2'd0);
    check("post-reset ri E2", 32'(read_index), 32'd1);
    check("post-reset px E2", pixel_out, rom_val(1));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/conv_layer_input_loader.md
# conv_layer_input_loader

Feeder side of the convolution layer's input row cache. It reads the image row by row from a synchronous single-port image ROM and streams pixels with the per-pixel `read_index`/`preload_cycle` tags that the cache consumes. It runs the preload of the first three rows and each subsequent single-row load, driven by the layer controller's 2-bit command/acknowledge handshake. It sits between the image ROM and the input cache.

## Interface

Parameters:

- `WIDTH`, 32: pixel word width (float32)
- `IMAGE_SIZE`, 8: pixels per row and rows per image
- `KERNEL_SIZE`, 3: rows streamed by a preload
- `ADDR_WIDTH`, 6: ROM address width
- `ROM_DEPTH`, 64: ROM words; must be ≥ `IMAGE_SIZE`*`IMAGE_SIZE`

Ports (one clock; reset is asynchronous and active-low):

- `clk`, in, 1: clock, rising edge
- `rst_n`, in, 1: asynchronous active-low reset
- `cmd`, in, 2: 0 = IDLE, 1 = PRELOAD_START, 2 = SHIFT_START, 3 = LOAD_START
- `rom_data`, in, `WIDTH`: ROM read data; valid one cycle after `rom_addr`
- `rom_addr`, out, `ADDR_WIDTH`: registered ROM address
- `pixel_out`, out, `WIDTH`: pixel to cache; a combinational pass-through of `rom_data`
- `read_index`, out, 5: column tag for `pixel_out`; 0–7 = pixel, 8 = bank-shift marker, 31 = idle
- `preload_cycle`, out, 2: row number within a preload
- `ack`, out, 2: 0 = IDLE, 1 = PRELOAD_FIN, 3 = LOAD_FIN; a one-cycle pulse
- `image_done`, out, 1: high when `row_ptr` == `IMAGE_SIZE`

## Operation

**States:** IDLE, PRELOAD, LOAD, ACK.

**Internal counters:**
- `row_ptr` (0..`IMAGE_SIZE`)
- `col` (0..`IMAGE_SIZE`)
- `prow` (0..2)

**Command acceptance:**
- `cmd` is sampled only in IDLE.
- Commands in any other state are ignored.
- SHIFT_START is ignored in every state: no stream and no ack.

**Addressing:**
- `rom_addr` = `row_ptr`*`IMAGE_SIZE` + `col`, truncated to `ADDR_WIDTH`.
- `rom_addr` holds its value while no new address is needed.

**PRELOAD:**
- On entry: `row_ptr` ← 0 and `prow` ← 0. `image_done` clears.
- For each `prow`, the ROM is read at columns 0..7. The tagged stream is `read_index` 0..7 with `pixel_out` = mem[`row_ptr`*8 + idx] and `preload_cycle` = `prow`.
- For `prow` < 2, one extra cycle follows with `read_index` = 8 (the shift marker).
  - During that cycle `pixel_out` is don't-care and address fetching pauses.
- `row_ptr` increments after each row.
- After `prow` 2 emits index 7, the block goes to ACK with `ack` = PRELOAD_FIN.
- `preload_cycle` then holds 3 until the next PRELOAD.
- Net result in the cache: bank0 = row0, bank1 = row1, bank2 = row2.

**LOAD:**
- If `row_ptr` < `IMAGE_SIZE`: stream `read_index` 0..7 for row `row_ptr`, then `row_ptr`++, then ACK with `ack` = LOAD_FIN.
- If `row_ptr` == `IMAGE_SIZE`: no stream. `read_index` stays 31 and the block goes directly to ACK with `ack` = LOAD_FIN.
- LOAD does not change `preload_cycle`.

**ACK:** `ack` is driven for exactly one cycle, then the block returns to IDLE with `ack` = 0.

**Idle outputs:** outside streaming cycles, `read_index` = 31, so the cache holds its contents.

**Reset (asynchronous, any time, including mid-stream):**
- State → IDLE
- `rom_addr` = 0, `read_index` = 31, `preload_cycle` = 0, `ack` = 0
- `row_ptr` = 0, `image_done` = 0
- `pixel_out` follows `rom_data`
- No partial ack is ever issued.

## Timing

**PRELOAD** (command sampled at edge E0):
- `rom_addr` = 0 after E0.
- `read_index` = 0 with `pixel_out` = mem[0] during E1–E2.
- Row 0 occupies 9 tag cycles, row 1 9, row 2 8: 26 contiguous tag cycles, after E1 through E26.
- `ack` = 1 during E27–E28. IDLE after E28.
- The earliest next command is sampled at E28.

**LOAD** (command sampled at E0, `row_ptr` = r < 8):
- `rom_addr` = 8r after E0.
- `read_index` 0..7 during E1–E9.
- `ack` = 3 during E9–E10. `row_ptr` = r+1 after E9.

**LOAD at end of image:** `ack` = 3 during E1–E2.

**ROM latency:** exactly one cycle. `read_index` is always registered one cycle behind the address that produced the current `rom_data`.

## Test plan

1. Reset mid-stream:
   - Stimulus: assert `rst_n` low at tag index 4 of a LOAD.
   - Response: immediately `read_index` = 31, `ack` = 0, `preload_cycle` = 0, `rom_addr` = 0. After release, the next PRELOAD starts from row 0.
2. PRELOAD on a ROM with mem[i] = i:
   - Stimulus: issue PRELOAD.
   - Response: the sequence (`read_index`, `preload_cycle`, `pixel_out`) equals (0..7,0,0..7), (8,0,x), (0..7,1,8..15), (8,1,x), (0..7,2,16..23).
   - Then `ack` = 1 for exactly 1 cycle at E27, then `preload_cycle` = 3. A cache model holds rows 0/1/2 in banks 0/1/2.
3. LOAD after PRELOAD:
   - Stimulus: issue LOAD.
   - Response: `pixel_out` 24..31 tagged 0..7 during E1–E9, `ack` = 3 at E9.
   - Five consecutive LOADs cover rows 3..7. After the last one, `image_done` = 1.
4. LOAD at end of image:
   - Stimulus: LOAD with `image_done` = 1.
   - Response: no tags (`read_index` stays 31), `ack` = 3 at E1.
   - A subsequent PRELOAD clears `image_done` and restarts at mem[0].
5. Ignored commands:
   - Stimulus: hold `cmd` = LOAD_START throughout a PRELOAD, and pulse SHIFT_START while in IDLE.
   - Response: the PRELOAD stream is unperturbed. SHIFT_START produces no ack or tags.
   - A held LOAD_START begins the load at the first IDLE cycle (E28).
